// File: rtl/regfile_mp_pkg.sv
// Shared defines for the multi-port register file: zero word, enable levels,
// sweep FSM encoding and default widths.
package regfile_mp_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int ADDR_W_DFLT = 5;

  localparam logic [DATA_W_DFLT-1:0] ZERO_WORD = '0;

  // Levels for we/re
  localparam logic LVL_EN  = 1'b1;
  localparam logic LVL_DIS = 1'b0;

  // Sweep FSM encoding
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: alloc sets, write clears, alloc wins on a
// same-edge collision. Register 0 is never busy.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next busy vector: clears from writes first, then the alloc so it wins
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] == LVL_EN && waddr[i*ADDR_W +: ADDR_W] != '0) begin
        busy_d[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (alloc_en && alloc_addr != '0) begin
      busy_d[alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state: cleared on reset, frozen while the sweep runs
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
    end else if (run) begin
      busy_q <= busy_d;
    end
  end

  // Lookup reflects state before any same-cycle update
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      rbusy[j] = run & re[j] & busy_q[raddr[j*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with post-reset zeroing sweep and busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr
);

  localparam int          NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  logic              state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              run;

  assign run   = (state_q == ST_RUN);
  assign ready = run;

  // Sweep FSM: reset restarts at register 1, last register hands over to RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= ADDR_W'(1);
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_q + ADDR_W'(1);
      if (cnt_q == CNT_LAST) begin
        state_q <= ST_RUN;
      end
    end
  end

  // Array update: sweep zeroes, otherwise later write ports override earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == ST_CLEAR) begin
        regs[cnt_q] <= DATA_W'(ZERO_WORD);
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] == LVL_EN && waddr[i*ADDR_W +: ADDR_W] != '0) begin
            regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Read muxes with optional same-cycle forwarding
  always_comb begin
    rdata = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (run && re[j] == LVL_EN && raddr[j*ADDR_W +: ADDR_W] != '0) begin
        rdata[j*DATA_W +: DATA_W] = regs[raddr[j*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] == LVL_EN && waddr[i*ADDR_W +: ADDR_W] != '0 &&
              waddr[i*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W]) begin
            rdata[j*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
          end
        end
`endif
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .we         (we),
    .waddr      (waddr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .re         (re),
    .raddr      (raddr),
    .rbusy      (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against a behavioural model of the file.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NREGS = 1 << AW;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_regs [NREGS];
  bit            m_busy [NREGS];
  bit            m_ready;
  int            m_left;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .re         (re),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rdata(int j);
    int a;
    logic [DW-1:0] v;
    a = int'(raddr[j*AW +: AW]);
    if (!m_ready || !re[j] || a == 0) return '0;
    v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < NW; i++) begin
      if (we[i] && int'(waddr[i*AW +: AW]) == a) v = wdata[i*DW +: DW];
    end
`endif
    return v;
  endfunction

  task automatic compare_outputs();
    check("ready", 64'(ready), 64'(m_ready));
    for (int j = 0; j < NR; j++) begin
      check("rdata", 64'(rdata[j*DW +: DW]), 64'(exp_rdata(j)));
      check("rbusy", 64'(rbusy[j]),
            64'(m_ready && re[j] && m_busy[int'(raddr[j*AW +: AW])]));
    end
  endtask

  task automatic model_edge();
    int a;
    if (!rst) begin
      m_ready = 0;
      m_left  = NREGS - 1;
      foreach (m_busy[k]) m_busy[k] = 0;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        foreach (m_regs[k]) m_regs[k] = '0;
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        a = int'(waddr[i*AW +: AW]);
        if (we[i] && a != 0) begin
          m_regs[a] = wdata[i*DW +: DW];
          m_busy[a] = 0;
        end
      end
      if (alloc_en && alloc_addr != 0) m_busy[int'(alloc_addr)] = 1;
    end
  endtask

  // One clock: check outputs for the current inputs, then advance the model
  task automatic cycle();
    #1;
    compare_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    we[p] = 1'b1; waddr[p*AW +: AW] = AW'(a); wdata[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    re[p] = 1'b1; raddr[p*AW +: AW] = AW'(a);
  endtask

  // Counts edges until ready; returns -1 if it never rises
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      cycle();
      n++;
    end
    if (!ready) n = -1;
  endtask

  int n;

  initial begin
    idle();
    rst = 1'b0;
    m_ready = 0; m_left = NREGS - 1;
    foreach (m_busy[k]) m_busy[k] = 0;
    foreach (m_regs[k]) m_regs[k] = '0;
    @(negedge clk);
    repeat (3) cycle();
    rst = 1'b1;

    // Full sweep, with we/alloc on r4 ignored throughout
    wr(0, 4, 32'h0000_4444);
    alloc_en = 1'b1; alloc_addr = 5'd4;
    rd(0, 4);
    wait_ready(n);
    check("sweep_len", 64'(n), 64'd31);
    idle();
    rd(0, 4); rd(1, 4);
    #1;
    check("r4_zero", 64'(rdata[DW-1:0]), 64'd0);
    check("r4_busy", 64'(rbusy[0]), 64'd0);
    cycle();
    for (int a = 1; a < NREGS; a++) begin
      idle(); rd(0, a); rd(1, a);
      cycle();
    end

    // Reset in the middle of a sweep restarts it
    rst = 1'b0; cycle(); idle();
    repeat (9) cycle();
    rst = 1'b0; cycle(); idle();
    wait_ready(n);
    check("resweep_len", 64'(n), 64'd31);

    // Write then read on both ports; write to r0 discarded
    idle(); wr(0, 7, 32'hDEAD_BEEF); wr(1, 0, 32'h1234); cycle();
    idle(); rd(0, 7); rd(1, 0);
    #1;
    check("r7_p0", 64'(rdata[DW-1:0]), 64'hDEAD_BEEF);
    check("r0_p1", 64'(rdata[2*DW-1:DW]), 64'd0);
    cycle();
    idle(); rd(1, 7); cycle();

    // Same-edge conflict: higher port wins
    idle(); wr(0, 5, 32'h11); wr(1, 5, 32'h22); cycle();
    idle(); rd(0, 5);
    #1;
    check("conflict", 64'(rdata[DW-1:0]), 64'h22);
    cycle();

    // Same-cycle read of a written register
    idle(); wr(0, 3, 32'hCAFE); rd(0, 3);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass", 64'(rdata[DW-1:0]), 64'hCAFE);
`else
    check("no_bypass", 64'(rdata[DW-1:0]), 64'h0);
`endif
    cycle();
    idle(); rd(0, 3);
    #1;
    check("r3_after", 64'(rdata[DW-1:0]), 64'hCAFE);
    cycle();

    // Scoreboard
    idle(); alloc_en = 1'b1; alloc_addr = 5'd9; cycle();
    idle(); rd(0, 9);
    #1;
    check("alloc_r9", 64'(rbusy[0]), 64'd1);
    wr(1, 9, 32'h99); cycle();
    idle(); rd(0, 9);
    #1;
    check("clear_r9", 64'(rbusy[0]), 64'd0);
    wr(0, 9, 32'h98); alloc_en = 1'b1; alloc_addr = 5'd9; cycle();
    idle(); rd(1, 9);
    #1;
    check("alloc_wins", 64'(rbusy[1]), 64'd1);
    alloc_en = 1'b1; alloc_addr = 5'd0; cycle();
    idle(); rd(0, 0);
    #1;
    check("alloc_r0", 64'(rbusy[0]), 64'd0);
    cycle();

    // Random traffic with occasional resets
    for (int t = 0; t < 600; t++) begin
      idle();
      if ($urandom_range(0, 249) == 0) rst = 1'b0;
      for (int i = 0; i < NW; i++) begin
        if ($urandom_range(0, 1) == 1)
          wr(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
             $urandom);
      end
      for (int j = 0; j < NR; j++) begin
        re[j] = ($urandom_range(0, 3) != 0);
        raddr[j*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                        : AW'($urandom_range(0, 31));
      end
      alloc_en = ($urandom_range(0, 2) == 0);
      alloc_addr = AW'($urandom_range(0, 7));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the MIPS integer pipeline. It supports a configurable number of read and write ports, so dual-issue decode and writeback can share one array. It adds a per-register busy scoreboard for issue stall decisions and a post-reset hardware sweep that zeroes every register. It sits between ID (read and allocate ports) and WB (write ports).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; the file holds 2^ADDR_W registers and register 0 is hardwired to zero
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- ready  out  1  high when the sweep has finished and the file accepts traffic
- we  in  NUM_WR  write enable per write port
- waddr  in  NUM_WR*ADDR_W  write address; port i uses slice [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, sliced the same way
- re  in  NUM_RD  read enable per read port
- raddr  in  NUM_RD*ADDR_W  read address
- rdata  out  NUM_RD*DATA_W  read data, combinational
- rbusy  out  NUM_RD  busy bit of raddr, combinational
- alloc_en  in  1  marks alloc_addr busy, meaning an instruction has issued that will produce it
- alloc_addr  in  ADDR_W  register being allocated

## Operation
- FSM states are CLEAR and RUN.
  - rst=0 forces CLEAR, sets sweep counter to 1, and clears all busy bits. This applies from either state, so a reset mid-sweep restarts the sweep at 1.
  - In CLEAR, each edge writes 0 to regs[cnt] and increments cnt.
  - When cnt equals 2^ADDR_W-1, that write completes and the FSM moves to RUN.
- ready = (state == RUN).
- While in CLEAR:
  - we and alloc_en are ignored.
  - rdata = 0 and rbusy = 0.
- Write in RUN: on the edge, if we[i] and waddr[i] != 0, regs[waddr[i]] <= wdata[i].
  - If two ports target the same address, the highest-index port wins.
  - Writes to address 0 are discarded.
- Read in RUN, per port j:
  - rdata[j] = 0 if re[j]=0 or raddr[j]=0.
  - Otherwise rdata[j] = regs[raddr[j]], subject to bypass (see Configuration).
- Scoreboard:
  - A write with we[i] and a nonzero address clears busy[waddr[i]].
  - alloc_en with alloc_addr != 0 sets busy[alloc_addr].
  - If a write and an alloc hit the same address on the same edge, busy ends up 1 (the new producer wins).
  - busy[0] is constant 0.
  - rbusy[j] = busy[raddr[j]] & re[j], evaluated before the same-cycle write takes effect. It is not bypassed.

## Timing
- Reset values: ready=0, rdata=0, rbusy=0, all busy bits 0.
- Register contents are undefined until the sweep completes.
- ready rises exactly 2^ADDR_W-1 edges after the first edge that samples rst=1; for ADDR_W=5 that is 31 edges.
- Read latency is 0 cycles (combinational from raddr/re).
- A write is visible in the array from the cycle after its edge.
- Scoreboard updates land on the edge and are visible in rbusy the next cycle.
- No backpressure: every accepted write and alloc completes in one cycle.

## Configuration
- REGFILE_BYPASS_EN defined: if raddr[j] matches any enabled, nonzero waddr[i] in the same cycle, rdata[j] = wdata[i]; the highest-index matching port wins, consistent with write priority.
- REGFILE_BYPASS_EN undefined: no forwarding. rdata returns the old array value in the write cycle and the new value from the next cycle. Forwarding is then the pipeline's responsibility.
- The macro affects RUN reads only. The CLEAR and scoreboard behaviour is identical either way.

## Structure
- The shared defines package holds:
  - the zero-word constant;
  - the enable/disable levels used for we/re;
  - the FSM state encoding (CLEAR=1'b0, RUN=1'b1);
  - defaults DATA_W=32 and ADDR_W=5.
- One sub-module, regfile_scoreboard, holds the busy bit vector, alloc/clear logic and rbusy lookup. It is parametrised by ADDR_W and NUM_RD/NUM_WR.
- The top level holds the array, sweep FSM, write-priority logic and read/bypass muxes.

## Test plan
- Reset sweep: hold rst=0 for 3 cycles, then release. ready=0 for 31 edges and then goes to 1; all 31 registers read 0. Pulsing rst=0 at sweep count 10 restarts the sweep and ready again needs 31 edges.
- Write/read: write 0xDEADBEEF to r7 on port 0, then read r7 on both ports next cycle, expecting 0xDEADBEEF. A write of 0x1234 to r0 must read back 0.
- Write conflict: port 0 writes 0x11 and port 1 writes 0x22 to r5 on the same edge. Next-cycle read of r5 returns 0x22.
- Bypass (macro on): in the same cycle, write 0xCAFE to r3 and read r3, expecting rdata=0xCAFE. With the macro off, the read returns the prior value 0x0 and 0xCAFE appears on the next cycle.
- Scoreboard: alloc r9, then rbusy=1 on the next cycle. A write to r9 clears it the cycle after. A simultaneous write and alloc on r9 leaves rbusy=1. Alloc of r0 keeps rbusy=0.
- During the sweep: asserting we and alloc_en for r4 has no effect. After ready, r4 reads 0 and rbusy is 0.
